pipe_stage_skid: RTL

Parametrised pipeline stage register that replaces the fixed-width, always-advancing stage registers between IF, ID, EXE, DM and WB. It adds a valid/ready handshake, a two-entry skid buffer so backpressure does not create a combinational ready chain, a synchronous flush for branch and call squash, and a saturating stall counter for performance debug. One instance sits between each pair of adjacent pipeline stages.

---
 rtl/pipe_stage_skid.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating upstream-stall counter.
module pipe_stage_skid #(
   parameter int unsigned        DATA_W     = 16,
   parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
   parameter int unsigned        CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_mreg;
   logic [DATA_W-1:0] r_sreg;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_mvalid;
   logic w_svalid;
   logic w_in_fire;
   logic w_out_fire;
   logic w_load_m_in;
   logic w_load_m_skid;
   logic w_load_s;
   logic w_stall;

   assign w_mvalid = (r_state != ST_EMPTY);
   assign w_svalid = (r_state == ST_FULL);

   // in_ready looks only at registered skid state, flush and reset, so
   // downstream backpressure never ripples combinationally upstream.
   assign in_ready   = rst & ~w_svalid & ~flush;
   assign out_valid  = w_mvalid & ~flush;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves a signal unassigned (which would infer a latch).
      w_state_nxt   = r_state;
      w_load_m_in   = 1'b0;
      w_load_m_skid = 1'b0;
      w_load_s      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_load_m_in = 1'b1;
                  w_state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_m_in = 1'b1;
               end else if (w_in_fire) begin
                  w_load_s    = 1'b1;
                  w_state_nxt = ST_FULL;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  w_load_m_skid = 1'b1;
                  w_state_nxt   = ST_ONE;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: payload registers carry no reset; they are only observable through
   // out_data when the state says they are valid, so reset would be wasted.
   always_ff @(posedge clk) begin
      if (w_load_m_in) begin
         r_mreg <= in_data;
      end else if (w_load_m_skid) begin
         r_mreg <= r_sreg;
      end
      if (w_load_s) begin
         r_sreg <= in_data;
      end
   end

   assign w_stall = in_valid & ~in_ready & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign out_data  = out_valid ? r_mreg : BUBBLE_VAL;
   assign occupancy = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule
